vga_line_fetch: RTL and testbench
=================================

Name: vga_line_fetch

Overview:
- Upstream neighbour of the VGA scanout/timing stage.
- Prefetches one 200-pixel line of 24-bit RGB from the shared framebuffer RAM into a ping-pong line buffer during the previous line.
- The scanout stage reads pixels by column with fixed 1-cycle latency, so display never touches the arbitrated framebuffer port directly.

Parameters:
- H_ACTIVE, 200, pixels per line.
- V_ACTIVE, 600, visible lines per frame.
- PIX_W, 24, pixel width ({R[23:16],G[15:8],B[7:0]}).
- ADDR_W, 17, framebuffer word address width (must hold H_ACTIVE*V_ACTIVE-1).

Ports:
- CLOCK_50  in  1  sole clock.
- RESET_N  in  1  synchronous, active-low reset.
- line_req  in  1  1-cycle pulse: start fetching line line_num into fill bank.
- line_num  in  10  line to fetch; sampled on line_req.
- swap  in  1  1-cycle pulse at line boundary: exchange display/fill banks.
- frame_start  in  1  1-cycle pulse at vsync: force display bank to 0.
- fb_rd_en  out  1  framebuffer read request.
- fb_rd_addr  out  ADDR_W  read word address.
- fb_rd_gnt  in  1  arbiter accepted request this cycle.
- fb_rd_data  in  PIX_W  read data; valid exactly 1 cycle after a granted cycle.
- pix_rd  in  1  scanout read strobe.
- pix_x  in  8  scanout column.
- pix_data  out  PIX_W  registered pixel, valid 1 cycle after pix_rd.
- busy  out  1  fetch in progress.
- line_done  out  1  1-cycle pulse when last pixel of a line is written.
- underrun  out  1  sticky error flag.

Behaviour:
- Reset (RESET_N low at CLOCK_50 edge):
  - State IDLE; fb_rd_en=0, fb_rd_addr=0, pix_data=0, busy=0, line_done=0, underrun=0.
  - disp_bank=0; fill_complete=0.
  - A fetch in flight is abandoned; a grant-data beat arriving the cycle after reset release is discarded.
- Banks:
  - Two H_ACTIVE x PIX_W buffers; fill bank = ~disp_bank.
  - swap toggles disp_bank; frame_start sets disp_bank=0.
  - frame_start wins over a simultaneous swap.
- States:
  - IDLE: on line_req with line_num < V_ACTIVE, latch base = line_num*H_ACTIVE, clear issue_col/wr_col/fill_complete, go FETCH. line_num >= V_ACTIVE is ignored (stay IDLE, no reads).
  - FETCH: fb_rd_en=1, fb_rd_addr=base+issue_col. issue_col++ on fb_rd_en&&fb_rd_gnt. After the grant for column H_ACTIVE-1, deassert fb_rd_en and go DRAIN.
  - DRAIN: wait for the final data beat, then go IDLE.
- Data path:
  - A beat registered 1 cycle after each grant writes fill_bank[wr_col]; wr_col++.
  - When wr_col reaches H_ACTIVE: line_done pulses 1 cycle, fill_complete=1.
- busy = (state != IDLE).
- Address arithmetic:
  - base uses full ADDR_W; the product is computed once per line, not per pixel.
  - No address wrap; the maximum address is 119999.
- line_req while busy: restart at the new line_num; set underrun=1. In-flight data for the aborted line is discarded.
- swap while busy or with fill_complete=0: still toggle banks; set underrun=1. The display shows whatever is in the bank.
- swap and line_req in the same cycle: swap applies first; the new fetch targets the new fill bank.
- Scanout read:
  - pix_rd: pix_data <= disp_bank[pix_x] next cycle, or 0 if pix_x >= H_ACTIVE.
  - pix_rd=0: pix_data holds its value.
  - A read of the display bank is unaffected by a swap in the same cycle (uses pre-swap bank).
- underrun clears only on reset.

Test Plan:
- Reset, then line_req, line_num=0, fb_rd_gnt tied 1, RAM returns data=addr: addresses 0..199 on 200 consecutive cycles. line_done 202 cycles after line_req. After swap, pix_rd with pix_x=5 gives pix_data=5 next cycle; underrun=0.
- line_num=599, grant toggling 1/0: 200 reads, addresses 119800..119999, none skipped or repeated. Bank contents match exactly after swap. Then line_num=600: no fb_rd_en, busy stays 0.
- Issue swap when only 150 of 200 pixels are written: underrun=1 and stays 1 through later good lines until RESET_N.
- Issue line_req for line 3 mid-fetch of line 2: fetch restarts at address 600. Bank holds line 3 only; underrun=1.
- pix_x=200 and pix_x=255 give pix_data=0. pix_rd=0 holds the previous value. frame_start together with swap leaves disp_bank=0.
- Drive RESET_N low for 1 cycle mid-FETCH: next cycle fb_rd_en=0, busy=0, pix_data=0. The late data beat does not corrupt the bank.

Source files
------------

// File: rtl/vga_line_fetch.sv
// Ping-pong line buffer: prefetches one framebuffer line into the fill bank
// while scanout reads the display bank with a fixed 1-cycle latency.
module vga_line_fetch #(
  parameter int unsigned H_ACTIVE = 200,
  parameter int unsigned V_ACTIVE = 600,
  parameter int unsigned PIX_W    = 24,
  parameter int unsigned ADDR_W   = 17
) (
  input  logic              CLOCK_50,
  input  logic              RESET_N,
  input  logic              line_req,
  input  logic [9:0]        line_num,
  input  logic              swap,
  input  logic              frame_start,
  output logic              fb_rd_en,
  output logic [ADDR_W-1:0] fb_rd_addr,
  input  logic              fb_rd_gnt,
  input  logic [PIX_W-1:0]  fb_rd_data,
  input  logic              pix_rd,
  input  logic [7:0]        pix_x,
  output logic [PIX_W-1:0]  pix_data,
  output logic              busy,
  output logic              line_done,
  output logic              underrun
);

  localparam int unsigned      COL_W    = $clog2(H_ACTIVE);
  localparam logic [COL_W-1:0] LAST_COL = COL_W'(H_ACTIVE - 1);
  localparam logic [9:0]       V_LIM    = 10'(V_ACTIVE);
  localparam logic [7:0]       H_PIX    = 8'(H_ACTIVE);
  localparam logic [ADDR_W-1:0] H_ADDR  = ADDR_W'(H_ACTIVE);

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    DRAIN
  } state_t;

  state_t             state_q, state_d;
  logic [ADDR_W-1:0]  base_q;
  logic [COL_W-1:0]   issue_col_q;
  logic [COL_W-1:0]   wr_col_q;
  logic               disp_bank_q;
  logic               fill_complete_q;
  logic               beat_q;
  logic               line_done_q;
  logic               underrun_q;
  logic [PIX_W-1:0]   pix_data_q;

  logic [PIX_W-1:0]   bank0 [H_ACTIVE];
  logic [PIX_W-1:0]   bank1 [H_ACTIVE];

  logic start;
  logic grant;
  logic wr_en;
  logic is_busy;

  assign is_busy = (state_q != IDLE);
  assign start   = line_req && (line_num < V_LIM);
  assign grant   = (state_q == FETCH) && fb_rd_gnt;
  // A beat belonging to a line being restarted, or landing on a reset edge, is dropped.
  assign wr_en   = RESET_N && beat_q && !start;

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:  if (start) state_d = FETCH;
      FETCH: begin
        if (start) begin
          state_d = FETCH;
        end else if (grant && (issue_col_q == LAST_COL)) begin
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (start) begin
          state_d = FETCH;
        end else if (beat_q) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLOCK_50) begin
    if (!RESET_N) begin
      state_q         <= IDLE;
      base_q          <= '0;
      issue_col_q     <= '0;
      wr_col_q        <= '0;
      disp_bank_q     <= 1'b0;
      fill_complete_q <= 1'b0;
      beat_q          <= 1'b0;
      line_done_q     <= 1'b0;
      underrun_q      <= 1'b0;
      pix_data_q      <= '0;
    end else begin
      state_q     <= state_d;
      beat_q      <= grant && !start;
      line_done_q <= 1'b0;

      if (start) begin
        base_q          <= ADDR_W'(line_num) * H_ADDR;
        issue_col_q     <= '0;
        wr_col_q        <= '0;
        fill_complete_q <= 1'b0;
      end else begin
        if (grant) begin
          issue_col_q <= issue_col_q + COL_W'(1);
        end
        if (beat_q) begin
          wr_col_q <= wr_col_q + COL_W'(1);
          if (wr_col_q == LAST_COL) begin
            line_done_q     <= 1'b1;
            fill_complete_q <= 1'b1;
          end
        end
      end

      if (frame_start) begin
        disp_bank_q <= 1'b0;
      end else if (swap) begin
        disp_bank_q <= ~disp_bank_q;
      end

      if ((start && is_busy) || (swap && (is_busy || !fill_complete_q))) begin
        underrun_q <= 1'b1;
      end

      // Reads the bank selected before any same-cycle swap takes effect.
      if (pix_rd) begin
        if (pix_x < H_PIX) begin
          pix_data_q <= disp_bank_q ? bank1[pix_x] : bank0[pix_x];
        end else begin
          pix_data_q <= '0;
        end
      end
    end
  end

  always_ff @(posedge CLOCK_50) begin
    if (wr_en) begin
      if (disp_bank_q) begin
        bank0[wr_col_q] <= fb_rd_data;
      end else begin
        bank1[wr_col_q] <= fb_rd_data;
      end
    end
  end

  assign fb_rd_en   = (state_q == FETCH);
  assign fb_rd_addr = (state_q == FETCH) ? (base_q + ADDR_W'(issue_col_q)) : '0;
  assign pix_data   = pix_data_q;
  assign busy       = is_busy;
  assign line_done  = line_done_q;
  assign underrun   = underrun_q;

endmodule

// File: tb/tb_vga_line_fetch.sv
// Directed bench for vga_line_fetch: expected read addresses and pixel values
// are queued by the stimulus and consumed by a negedge monitor.
module tb_vga_line_fetch;

  logic        CLOCK_50;
  logic        RESET_N;
  logic        line_req;
  logic [9:0]  line_num;
  logic        swap;
  logic        frame_start;
  logic        fb_rd_en;
  logic [16:0] fb_rd_addr;
  logic        fb_rd_gnt;
  logic [23:0] fb_rd_data;
  logic        pix_rd;
  logic [7:0]  pix_x;
  logic [23:0] pix_data;
  logic        busy;
  logic        line_done;
  logic        underrun;

  vga_line_fetch #(
    .H_ACTIVE(200),
    .V_ACTIVE(600),
    .PIX_W(24),
    .ADDR_W(17)
  ) dut (
    .CLOCK_50(CLOCK_50),
    .RESET_N(RESET_N),
    .line_req(line_req),
    .line_num(line_num),
    .swap(swap),
    .frame_start(frame_start),
    .fb_rd_en(fb_rd_en),
    .fb_rd_addr(fb_rd_addr),
    .fb_rd_gnt(fb_rd_gnt),
    .fb_rd_data(fb_rd_data),
    .pix_rd(pix_rd),
    .pix_x(pix_x),
    .pix_data(pix_data),
    .busy(busy),
    .line_done(line_done),
    .underrun(underrun)
  );

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int done_cnt = 0;
  int done_cyc = 0;
  bit saw_en   = 0;
  bit saw_busy = 0;
  bit pix_pend = 0;
  int addr_q[$];
  int pix_q[$];

  initial CLOCK_50 = 1'b0;
  always #5 CLOCK_50 = ~CLOCK_50;

  always @(posedge CLOCK_50) cyc <= cyc + 1;

  // Framebuffer RAM model: data = address, one cycle after a granted request.
  always @(posedge CLOCK_50) begin
    if (fb_rd_en && fb_rd_gnt) fb_rd_data <= 24'(fb_rd_addr);
    else fb_rd_data <= 24'hA5A5A5;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(negedge CLOCK_50) begin
    if (fb_rd_en) saw_en = 1;
    if (busy) saw_busy = 1;
    if (line_done) begin
      done_cnt++;
      done_cyc = cyc;
    end
    if (fb_rd_en && fb_rd_gnt) begin
      if (addr_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL rd_addr: unexpected read at addr %0d (cycle %0d)", fb_rd_addr, cyc);
      end else begin
        check("rd_addr", 32'(fb_rd_addr), addr_q.pop_front());
      end
    end
    if (pix_pend) begin
      if (pix_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL pix_data: no expected value queued, got %0d", pix_data);
      end else begin
        check("pix_data", 32'(pix_data), pix_q.pop_front());
      end
    end
    pix_pend = pix_rd;
  end

  task automatic step();
    @(posedge CLOCK_50);
    #1;
  endtask

  task automatic push_line(input int first, input int n);
    for (int i = 0; i < n; i++) addr_q.push_back(first + i);
  endtask

  task automatic pulse_req(input int n);
    line_num = 10'(n);
    line_req = 1'b1;
    step();
    line_req = 1'b0;
  endtask

  task automatic pulse_swap();
    swap = 1'b1;
    step();
    swap = 1'b0;
  endtask

  task automatic pix_read(input int x, input int exp);
    pix_q.push_back(exp);
    pix_x  = 8'(x);
    pix_rd = 1'b1;
    step();
    pix_rd = 1'b0;
  endtask

  task automatic wait_idle(input string name, input bit toggle);
    int n = 0;
    while (busy && n < 2000) begin
      if (toggle) fb_rd_gnt = ~fb_rd_gnt;
      step();
      n++;
    end
    check(name, 32'(busy), 0);
    step();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int req_cyc;
    int d0;
    RESET_N = 1'b0; line_req = 1'b0; line_num = '0; swap = 1'b0; frame_start = 1'b0;
    fb_rd_gnt = 1'b0; pix_rd = 1'b0; pix_x = '0;
    repeat (3) step();
    RESET_N = 1'b1;
    check("rst_en", 32'(fb_rd_en), 0);
    check("rst_addr", 32'(fb_rd_addr), 0);
    check("rst_pix", 32'(pix_data), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_done", 32'(line_done), 0);
    check("rst_underrun", 32'(underrun), 0);

    // Line 0, grant always high: back-to-back reads and fixed latency.
    fb_rd_gnt = 1'b1;
    push_line(0, 200);
    req_cyc = cyc;
    d0 = done_cnt;
    pulse_req(0);
    wait_idle("l0_idle", 0);
    check("l0_latency", 32'(done_cyc - req_cyc), 202);
    check("l0_done_pulses", 32'(done_cnt - d0), 1);
    check("l0_addr_left", 32'(addr_q.size()), 0);
    pulse_swap();
    pix_read(5, 5);
    pix_read(0, 0);
    pix_read(199, 199);
    check("l0_underrun", 32'(underrun), 0);

    // Last line with alternating grants.
    fb_rd_gnt = 1'b0;
    push_line(119800, 200);
    pulse_req(599);
    wait_idle("l599_idle", 1);
    check("l599_addr_left", 32'(addr_q.size()), 0);
    pulse_swap();
    pix_read(0, 119800);
    pix_read(100, 119900);
    pix_read(199, 119999);
    check("l599_underrun", 32'(underrun), 0);

    // Out-of-range line is ignored.
    fb_rd_gnt = 1'b1;
    saw_en = 0;
    saw_busy = 0;
    pulse_req(600);
    repeat (5) step();
    check("l600_no_read", 32'(saw_en), 0);
    check("l600_no_busy", 32'(saw_busy), 0);

    // Column bounds, hold, same-cycle swap, frame_start priority.
    pix_read(200, 0);
    pix_read(255, 0);
    pix_read(7, 119807);
    pix_x = 8'd3;
    step();
    step();
    check("pix_hold", 32'(pix_data), 119807);
    pix_q.push_back(119809);
    pix_x = 8'd9; pix_rd = 1'b1; swap = 1'b1;
    step();
    pix_rd = 1'b0; swap = 1'b0;
    pix_read(5, 5);
    frame_start = 1'b1; swap = 1'b1;
    step();
    frame_start = 1'b0; swap = 1'b0;
    pix_read(5, 119805);
    check("fs_underrun", 32'(underrun), 0);

    // Swap while only ~150 pixels have landed.
    push_line(200, 200);
    pulse_req(1);
    repeat (150) step();
    pulse_swap();
    wait_idle("l1_idle", 0);
    check("early_swap_underrun", 32'(underrun), 1);
    check("l1_addr_left", 32'(addr_q.size()), 0);

    // Restart line 2 -> line 3 after 40 grants.
    fb_rd_gnt = 1'b0;
    push_line(400, 40);
    pulse_req(2);
    fb_rd_gnt = 1'b1;
    repeat (40) step();
    fb_rd_gnt = 1'b0;
    pulse_req(3);
    push_line(600, 200);
    fb_rd_gnt = 1'b1;
    wait_idle("l3_idle", 0);
    check("restart_underrun", 32'(underrun), 1);
    check("l3_addr_left", 32'(addr_q.size()), 0);
    pulse_swap();
    pix_read(0, 600);
    pix_read(1, 601);
    pix_read(39, 639);
    pix_read(40, 640);
    pix_read(199, 799);

    // A clean line afterwards keeps underrun set.
    push_line(800, 200);
    pulse_req(4);
    wait_idle("l4_idle", 0);
    check("sticky_underrun", 32'(underrun), 1);
    pulse_swap();
    pix_read(0, 800);
    pix_read(199, 999);

    // Reset in the middle of a fetch; the trailing beat must not land anywhere.
    fb_rd_gnt = 1'b0;
    push_line(1000, 21);
    pulse_req(5);
    fb_rd_gnt = 1'b1;
    repeat (20) step();
    RESET_N = 1'b0;
    step();
    RESET_N = 1'b1;
    fb_rd_gnt = 1'b0;
    check("mid_rst_en", 32'(fb_rd_en), 0);
    check("mid_rst_busy", 32'(busy), 0);
    check("mid_rst_pix", 32'(pix_data), 0);
    check("mid_rst_underrun", 32'(underrun), 0);
    step();
    step();
    check("mid_rst_addr_left", 32'(addr_q.size()), 0);
    pulse_swap();
    check("post_rst_swap_underrun", 32'(underrun), 1);
    pix_read(0, 800);
    pix_read(1, 801);
    step();
    check("pix_left", 32'(pix_q.size()), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
